serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder built around one full_adder instance.
//   Shift registers feed the cell LSB-first, one bit per clock.
//   A carry flip-flop stores the cell's cout and returns it as cin on the next bit.
//   Trades latency for area. Sits between a register-file/operand source and any
//   consumer that accepts a done-qualified result.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range 2..32
// PORTS
//   clk    in   1      rising-edge clock, single clock domain
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  operand A; captured on accepted start
//   b      in   WIDTH  operand B; captured on accepted start
//   cin    in   1      carry-in; captured on accepted start
//   busy   out  1      high whenever state != IDLE
//   done   out  1      one-cycle pulse: sum/cout just updated
//   sum    out  WIDTH  registered result; held until next completion
//   cout   out  1      registered carry-out of MSB; held with sum
// BEHAVIOUR
//   Reset (rst_n=0, async)
//     - state=IDLE; busy=0, done=0, sum=0, cout=0.
//     - Shift registers, carry FF and bit counter all cleared.
//   Internal state
//     - a_sh, b_sh, sum_sh: WIDTH-bit shift registers.
//     - carry: 1-bit flip-flop.
//     - cnt: $clog2(WIDTH)-bit bit counter.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE
//     - IDLE:  on start=1 at edge T0: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0,
//              sum_sh<=0; go to SHIFT. If start=0, stay in IDLE.
//     - SHIFT: the full_adder sees (a_sh[0], b_sh[0], carry) and produces (s, c).
//              Each edge: sum_sh<={s,sum_sh[WIDTH-1:1]}; a_sh>>=1; b_sh>>=1;
//              carry<=c; cnt<=cnt+1.
//              On the edge where cnt==WIDTH-1: sum<={s,sum_sh[WIDTH-1:1]},
//              cout<=c; go to DONE.
//     - DONE:  done=1 for this single cycle; next edge returns to IDLE.
//   Timing
//     - start accepted at edge T0.
//     - Bits are processed on edges T1..TWIDTH.
//     - done=1 during the cycle following TWIDTH.
//     - busy=1 from T0 until the edge TWIDTH+1.
//     - Issue interval is WIDTH+2 cycles.
//   Handshake and boundary conditions
//     - start is ignored while in SHIFT and DONE; there is no queueing.
//       A request is accepted only when start=1 with busy=0.
//     - a, b and cin may change freely after T0; only the captured copies are used.
//     - sum and cout change only on the edge entering DONE; they stay stable otherwise.
//     - Overflow wraps: sum = (a+b+cin) mod 2^WIDTH, cout = bit WIDTH.
//     - Reset mid-operation aborts immediately: done does not pulse; sum and cout return to 0.
//     - start held high continuously: a new operation begins on the first IDLE cycle,
//       every WIDTH+2 cycles.
// TESTING  (WIDTH=8 unless stated)
//   1. After reset, no start -> busy=0, done=0, sum=0x00, cout=0 for 20 cycles.
//   2. a=0x35, b=0x4A, cin=0, start pulsed -> done exactly 9 cycles after the accept
//      edge; sum=0x7F, cout=0.
//   3. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple).
//      Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
//   4. start re-pulsed during SHIFT with a=0x11 -> ignored; first result unchanged.
//      sum/cout hold after done until the next completion.
//   5. rst_n dropped at the 4th SHIFT cycle -> busy, sum and cout go to 0 asynchronously;
//      no done pulse. A fresh op after release gives the correct result.
//   6. Random a/b/cin, 1000 ops with start held high, WIDTH=8 and WIDTH=16 ->
//      every sum/cout matches a+b+cin; done spacing is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
//   Request/result bundle for the bit-serial adder.
//
//   Signals
//     start  request; the adder samples it only while idle
//     a, b   WIDTH-bit operands, captured on an accepted start
//     cin    carry-in, captured on an accepted start
//     busy   high while an operation is in progress
//     done   one-cycle pulse when sum/cout have just been updated
//     sum    registered WIDTH-bit result, held until the next completion
//     cout   registered carry-out of the MSB, held with sum
//
//   Modports
//     master  operand source: drives start/a/b/cin, observes results
//     slave   the adder itself: observes the request, drives results
// ---------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface : serial_adder_if

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder built around a single full-adder cell.
//   Operands are captured into shift registers and fed to the cell LSB
//   first, one bit per clock; a carry flip-flop returns the cell's carry
//   as the carry-in of the next bit. The result is published together
//   with a one-cycle done pulse and held until the next completion.
//
//   Ports
//     clk    rising-edge clock, single clock domain
//     rst_n  asynchronous active-low reset
//     bus    serial_adder_if.slave : start/a/b/cin in, busy/done/sum/cout out
//
//   Parameters
//     WIDTH  operand/sum width in bits, 2..32
//
//   Timing (start accepted at edge T0)
//     bits processed on edges T1..TWIDTH, done high in the cycle after
//     TWIDTH, back in IDLE after TWIDTH+1; issue interval WIDTH+2 cycles.
// ---------------------------------------------------------------------------

// One-bit full adder: the only arithmetic in the serial datapath.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   logic w_p;

   // Propagate term is shared by sum and carry.
   assign w_p    = i_a ^ i_b;
   assign o_s    = w_p ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule : full_adder

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_s;
   logic               w_c;
   logic               w_last_bit;
   logic [WIDTH-1:0]   w_sum_next;

   // -------------------------------------------------------------------
   // Arithmetic cell: always looks at the current LSBs and stored carry.
   // -------------------------------------------------------------------
   full_adder u_fa (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_c)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts the LSB of
   // the result has arrived at bit 0.
   assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
   assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

   // -------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // -------------------------------------------------------------------
   // FSM next-state logic
   // -------------------------------------------------------------------
   // NOTE: the default assignment up front keeps this purely combinational;
   // any path that left w_next_state unassigned would infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next_state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last_bit) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------
   // Datapath: operand capture, serial shift, result publication
   // -------------------------------------------------------------------
   // NOTE: every datapath register is cleared by reset, including the
   // shift registers; an aborted operation must leave no residue visible
   // on sum/cout and the next operation starts from a known state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Inputs are copied here; later changes on a/b/cin are ignored.
               if (bus.start) begin
                  r_a_sh   <= bus.a;
                  r_b_sh   <= bus.b;
                  r_carry  <= bus.cin;
                  r_sum_sh <= '0;
                  r_cnt    <= '0;
               end
            end
            S_SHIFT: begin
               r_sum_sh <= w_sum_next;
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_carry  <= w_c;
               r_cnt    <= r_cnt + 1'b1;
               // The published result only moves on the edge entering DONE.
               if (w_last_bit) begin
                  r_sum  <= w_sum_next;
                  r_cout <= w_c;
               end
            end
            default: begin
               // DONE: hold everything; the result is already published.
            end
         endcase
      end
   end

   // -------------------------------------------------------------------
   // Outputs: status decoded straight from the state register
   // -------------------------------------------------------------------
   assign bus.busy = (r_state != S_IDLE);
   assign bus.done = (r_state == S_DONE);
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder. An 8-bit and a 16-bit instance
//   share clock and reset. Directed operations come from a vector table,
//   corner cases (re-pulsed start, mid-operation reset) are hand-written,
//   and a random phase holds start high on both instances. Expected
//   results are pushed to a scoreboard queue when an operation is issued
//   and popped when done pulses. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8))  bus8  ();
   serial_adder_if #(.WIDTH(16)) bus16 ();

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   // Index 0 drives/observes the 8-bit instance, index 1 the 16-bit one.
   logic [31:0] drv_a     [2];
   logic [31:0] drv_b     [2];
   logic        drv_cin   [2];
   logic        drv_start [2];

   logic        obs_busy [2];
   logic        obs_done [2];
   logic        obs_cout [2];
   logic [31:0] obs_sum  [2];

   assign bus8.start  = drv_start[0];
   assign bus8.a      = drv_a[0][7:0];
   assign bus8.b      = drv_b[0][7:0];
   assign bus8.cin    = drv_cin[0];
   assign bus16.start = drv_start[1];
   assign bus16.a     = drv_a[1][15:0];
   assign bus16.b     = drv_b[1][15:0];
   assign bus16.cin   = drv_cin[1];

   assign obs_busy[0] = bus8.busy;
   assign obs_done[0] = bus8.done;
   assign obs_cout[0] = bus8.cout;
   assign obs_sum[0]  = {24'd0, bus8.sum};
   assign obs_busy[1] = bus16.busy;
   assign obs_done[1] = bus16.done;
   assign obs_cout[1] = bus16.cout;
   assign obs_sum[1]  = {16'd0, bus16.sum};

   // Scoreboards hold {cout, sum[31:0]} per issued operation.
   logic [32:0] sbq0 [$];
   logic [32:0] sbq1 [$];

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One directed 8-bit operation. Latency is counted in edges after the
   // accept edge T0; done must first be seen after edge T8. With repulse
   // set, start is raised again with a=0x11 during SHIFT and must be ignored.
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec, input bit repulse);
      logic [32:0] exp;
      logic [32:0] held;
      int          k;
      @(negedge clk);
      check("idle_before_op", obs_busy[0], 1'b0);
      held         = {obs_cout[0], obs_sum[0]};
      drv_a[0]     = {24'd0, a};
      drv_b[0]     = {24'd0, b};
      drv_cin[0]   = c;
      drv_start[0] = 1'b1;
      sbq0.push_back({ec, 24'd0, es});
      @(negedge clk);
      // Scramble the inputs: only the captured copies may matter.
      drv_start[0] = 1'b0;
      drv_a[0]     = ~drv_a[0];
      drv_b[0]     = $urandom;
      drv_cin[0]   = ~c;
      check("busy_after_accept", obs_busy[0], 1'b1);
      k = 0;
      while (!obs_done[0] && k < 20) begin
         check("result_held_in_shift", {obs_cout[0], obs_sum[0]}, held);
         if (repulse && k == 3) begin
            drv_start[0] = 1'b1;
            drv_a[0]     = 32'h11;
         end else begin
            drv_start[0] = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      check("done_latency_edges", k, 8);
      check("sb_nonempty8", sbq0.size() != 0, 1'b1);
      if (obs_done[0] && sbq0.size() != 0) begin
         exp = sbq0.pop_front();
         check("directed_result", {obs_cout[0], obs_sum[0]}, exp);
         held = exp;
      end
      @(negedge clk);
      check("done_one_cycle", obs_done[0], 1'b0);
      check("idle_after_done", obs_busy[0], 1'b0);
      if (repulse) begin
         // A queued re-pulse would restart the adder here.
         repeat (3) begin
            @(negedge clk);
            check("no_queued_start", {obs_busy[0], obs_done[0]}, 2'b00);
            check("result_held_after_done", {obs_cout[0], obs_sum[0]}, held);
         end
      end
   endtask

   initial begin
      int          issued [2];
      int          got    [2];
      int          last_done [2];
      int          cyc;
      int          wd;
      logic [31:0] mask;
      logic [32:0] tot;
      logic [32:0] exp;

      tbl[0] = '{a: 8'h35, b: 8'h4A, cin: 1'b0, sum: 8'h7F, cout: 1'b0};
      tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
      tbl[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
      tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
      tbl[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
      tbl[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1};
      tbl[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};
      tbl[7] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0};

      for (int w = 0; w < 2; w++) begin
         drv_a[w]     = '0;
         drv_b[w]     = '0;
         drv_cin[w]   = 1'b0;
         drv_start[w] = 1'b0;
      end

      // Reset, then 20 idle cycles with everything at zero.
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("reset_idle8",  {obs_busy[0], obs_done[0], obs_cout[0], obs_sum[0]}, '0);
         check("reset_idle16", {obs_busy[1], obs_done[1], obs_cout[1], obs_sum[1]}, '0);
      end

      // Table-driven directed operations.
      for (int i = 0; i < 8; i++) begin
         run_op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, 1'b0);
      end

      // start re-pulsed during SHIFT is ignored; result holds afterwards.
      run_op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b1);

      // Leave a non-zero published result, then reset during the 4th SHIFT cycle.
      run_op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      @(negedge clk);
      drv_a[0]     = 32'h0F;
      drv_b[0]     = 32'h0F;
      drv_cin[0]   = 1'b0;
      drv_start[0] = 1'b1;
      @(negedge clk);
      drv_start[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_before_abort", obs_busy[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_reset_clears", {obs_busy[0], obs_done[0], obs_cout[0], obs_sum[0]}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("no_done_after_abort", {obs_busy[0], obs_done[0], obs_cout[0], obs_sum[0]}, '0);
      end
      run_op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);

      // Random back-to-back operations with start held high on both widths.
      for (int w = 0; w < 2; w++) begin
         issued[w]    = 0;
         got[w]       = 0;
         last_done[w] = -1;
      end
      cyc = 0;
      while ((got[0] < 1000 || got[1] < 1000) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         for (int w = 0; w < 2; w++) begin
            wd   = (w == 0) ? 8 : 16;
            mask = (32'h1 << wd) - 32'h1;
            if (obs_done[w]) begin
               exp = '0;
               if (w == 0) begin
                  check("sb_nonempty_rand8", sbq0.size() != 0, 1'b1);
                  if (sbq0.size() != 0) exp = sbq0.pop_front();
                  check("rand8_result", {obs_cout[0], obs_sum[0]}, exp);
               end else begin
                  check("sb_nonempty_rand16", sbq1.size() != 0, 1'b1);
                  if (sbq1.size() != 0) exp = sbq1.pop_front();
                  check("rand16_result", {obs_cout[1], obs_sum[1]}, exp);
               end
               if (last_done[w] >= 0) begin
                  check(w == 0 ? "done_spacing8" : "done_spacing16", cyc - last_done[w], wd + 2);
               end
               last_done[w] = cyc;
               got[w]++;
            end
            if (!obs_busy[w]) begin
               // Idle now, so the next rising edge accepts whatever is driven.
               if (issued[w] < 1000) begin
                  drv_a[w]     = $urandom & mask;
                  drv_b[w]     = $urandom & mask;
                  drv_cin[w]   = 1'($urandom_range(0, 1));
                  drv_start[w] = 1'b1;
                  tot = {1'b0, drv_a[w]} + {1'b0, drv_b[w]} + {32'd0, drv_cin[w]};
                  exp = {tot[wd], tot[31:0] & mask};
                  if (w == 0) sbq0.push_back(exp);
                  else        sbq1.push_back(exp);
                  issued[w]++;
               end else begin
                  drv_start[w] = 1'b0;
               end
            end else begin
               drv_a[w]   = $urandom & mask;
               drv_b[w]   = $urandom & mask;
               drv_cin[w] = 1'($urandom_range(0, 1));
            end
         end
      end
      check("rand8_completions",  got[0], 1000);
      check("rand16_completions", got[1], 1000);
      check("sb_drained8",  sbq0.size(), 0);
      check("sb_drained16", sbq1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_adder
